memoria_datos_hs: RTL

- Byte-addressed, big-endian data memory for the datapath load/store stage.
- Successor to the single-word data memory, with these additions:
  - parametrised depth and address width
  - byte/half/word accesses with signed or unsigned loads
  - misalignment and range checking
  - valid/ready request and response handshake with a registered read
- After reset, a clearing state machine zeroes the array before the first request is accepted.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_load_align.sv | 25 ++
 rtl/memoria_datos_hs.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the memoria_datos_hs data memory.
//   size_e      : access size codes carried on req_size
//   state_e     : controller states (array clear, idle, response pending)
//   size_nbytes : number of bytes touched by a given size code
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        RESP  = 2'd2
    } state_e;

    // Reserved size returns 0; such requests are flagged as errors anyway.
    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            2'd0:    size_nbytes = 3'd1;
            2'd1:    size_nbytes = 3'd2;
            2'd2:    size_nbytes = 3'd4;
            default: size_nbytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load result formatter for memoria_datos_hs (purely combinational).
//   fetched     in  32  the four fetched bytes, rotated so the first accessed
//                       byte sits in [31:24] (big-endian order)
//   size        in  2   access size code
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend byte/half results
//   result      out 32  right-justified, extended load value
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] fetched,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    always_comb begin
        result = fetched;
        case (size_e'(size))
            SZ_BYTE: result = {{24{~is_unsigned & fetched[31]}}, fetched[31:24]};
            SZ_HALF: result = {{16{~is_unsigned & fetched[31]}}, fetched[31:16]};
            default: result = fetched;
        endcase
    end

endmodule

// File: rtl/memoria_datos_hs.sv
// Byte-addressed big-endian data memory with valid/ready handshake.
// After reset the array is zeroed one word per cycle before requests are taken.
// Ports:
//   clk, rst_n (synchronous, active-low)
//   req_valid/req_ready, req_write, req_size, req_unsigned, address, write_data
//   resp_valid/resp_ready, read_data, resp_err
//   init_done   high once the array clear has finished
// Optional: define DMEM_TRACE_EN to print store and error trace lines.
//
// The array is split into four byte banks (one per byte lane, bank 0 holding
// the lowest address of each word) so byte/half stores become per-bank write
// enables and every bank is a plain single-port RAM with a registered read.
module memoria_datos_hs
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       read_data,
    output logic              resp_err,
    output logic              init_done
);

    localparam int WORDS     = DEPTH_BYTES / 4;
    localparam int CLR_PTR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CLR_PTR_W-1:0] LAST_WORD = CLR_PTR_W'(WORDS - 1);

    state_e                 state_reg, state_next;
    logic [CLR_PTR_W-1:0]   clr_ptr_reg;
    logic                   init_done_reg;
    logic                   resp_err_reg;
    logic                   resp_load_reg;   // response carries load data
    logic [1:0]             resp_size_reg;
    logic                   resp_uns_reg;
    logic [1:0]             resp_lane_reg;

    logic                   accept;
    logic                   req_err;
    logic [2:0]             nbytes;
    logic [ADDR_W-1:0]      limit;
    logic [1:0]             lane;
    logic [CLR_PTR_W-1:0]   word_idx;
    logic [CLR_PTR_W-1:0]   ram_idx;
    logic [3:0]             byte_en;
    logic [31:0]            wr_aligned;      // store data placed on its lanes
    logic [3:0]             bank_we;
    logic [31:0]            fetched_word;    // bank outputs, bank 0 in [31:24]
    logic [31:0]            fetched_rot;
    logic [31:0]            load_value;

    assign lane      = address[1:0];
    assign word_idx  = address[CLR_PTR_W+1:2];
    assign accept    = req_valid && req_ready;
    assign req_ready = (state_reg == IDLE) || ((state_reg == RESP) && resp_ready);

    // Error decode; the range compare is done at full address width so high
    // addresses never alias back into the array.
    always_comb begin
        nbytes  = size_nbytes(req_size);
        limit   = ADDR_W'(DEPTH_BYTES) - ADDR_W'(nbytes);
        req_err = 1'b0;
        case (size_e'(req_size))
            SZ_RSVD: req_err = 1'b1;
            SZ_HALF: if (address[0])         req_err = 1'b1;
            SZ_WORD: if (address[1:0] != 2'b00) req_err = 1'b1;
            default: ;
        endcase
        if (address > limit) req_err = 1'b1;
    end

    // Right-justified store data shifted onto the big-endian byte lanes.
    always_comb begin
        byte_en    = 4'b0000;
        wr_aligned = 32'h0;
        case (size_e'(req_size))
            SZ_BYTE: begin
                byte_en    = 4'b0001 << lane;
                wr_aligned = {write_data[7:0], 24'h0} >> {lane, 3'b000};
            end
            SZ_HALF: begin
                byte_en    = 4'b0011 << lane;
                wr_aligned = {write_data[15:0], 16'h0} >> {lane, 3'b000};
            end
            SZ_WORD: begin
                byte_en    = 4'b1111;
                wr_aligned = write_data;
            end
            default: ;
        endcase
    end

    assign ram_idx = (state_reg == CLEAR) ? clr_ptr_reg : word_idx;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bank
            logic [7:0] mem [WORDS];
            logic [7:0] wbyte;
            logic [7:0] q_reg;

            assign bank_we[gi] = (state_reg == CLEAR) ||
                                 (accept && req_write && !req_err && byte_en[gi]);
            assign wbyte = (state_reg == CLEAR) ? 8'h00 : wr_aligned[31-8*gi -: 8];

            // Read samples the pre-write contents; a store and load never
            // share an edge, so no forwarding is needed.
            always_ff @(posedge clk) begin
                if (bank_we[gi]) mem[ram_idx] <= wbyte;
                if (accept)      q_reg        <= mem[ram_idx];
            end

            assign fetched_word[31-8*gi -: 8] = q_reg;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CLEAR:   if (clr_ptr_reg == LAST_WORD) state_next = IDLE;
            IDLE:    if (accept) state_next = RESP;
            RESP:    if (resp_ready && !accept) state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= CLEAR;
            clr_ptr_reg   <= '0;
            init_done_reg <= 1'b0;
            resp_err_reg  <= 1'b0;
            resp_load_reg <= 1'b0;
            resp_size_reg <= 2'd0;
            resp_uns_reg  <= 1'b0;
            resp_lane_reg <= 2'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == CLEAR) begin
                clr_ptr_reg <= clr_ptr_reg + CLR_PTR_W'(1);
                if (clr_ptr_reg == LAST_WORD) init_done_reg <= 1'b1;
            end
            if (accept) begin
                resp_err_reg  <= req_err;
                resp_load_reg <= !req_write && !req_err;
                resp_size_reg <= req_size;
                resp_uns_reg  <= req_unsigned;
                resp_lane_reg <= lane;
            end
        end
    end

    // Rotate so the first accessed byte lands in [31:24] for the formatter.
    assign fetched_rot = fetched_word << {resp_lane_reg, 3'b000};

    dmem_load_align u_load_align (
        .fetched     (fetched_rot),
        .size        (resp_size_reg),
        .is_unsigned (resp_uns_reg),
        .result      (load_value)
    );

    assign resp_valid = (state_reg == RESP);
    assign read_data  = resp_load_reg ? load_value : 32'h0;
    assign resp_err   = resp_err_reg;
    assign init_done  = init_done_reg;

`ifdef DMEM_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            if (req_err)
                $display("MEM ERR: Dir[%0d] size %0d", address, req_size);
            else if (req_write)
                $display("MEM WRITE: Dir[%0d] = %0d (Hex: %h) size %0d",
                         address, write_data, write_data, nbytes);
        end
    end
`endif

endmodule
